// File: rtl/data_memory_be.sv
// Single-port word memory with per-byte write enables, registered read data
// and an optional zero-fill sweep of every word after reset.
module data_memory_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req,
  input  logic                    wr_enable,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic [DATA_WIDTH/8-1:0] byte_en,
  output logic                    ready,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    dout_valid,
  output logic                    addr_err
);

  localparam int NUM_BYTES = DATA_WIDTH / 8;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_clearCnt;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic                    r_doutValid;
  logic                    r_addrErr;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic w_ready;
  logic w_accept;
  logic w_inRange;
  logic w_lastClear;
  logic w_clearWe;
  logic w_wrAccept;

  assign w_ready     = (r_state == RUN);
  assign w_accept    = req & w_ready;
  // Extra bit keeps DEPTH == 2**ADDR_WIDTH representable in the comparison.
  assign w_inRange   = ({1'b0, address} < (ADDR_WIDTH+1)'(DEPTH));
  assign w_lastClear = (r_clearCnt == ADDR_WIDTH'(DEPTH - 1));
  assign w_clearWe   = reset_n && (r_state == CLEAR) && (CLEAR_ON_RESET != 0);
  assign w_wrAccept  = w_accept & wr_enable & w_inRange;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= CLEAR;
      r_clearCnt  <= '0;
      r_dout      <= '0;
      r_doutValid <= 1'b0;
      r_addrErr   <= 1'b0;
    end else begin
      r_doutValid <= 1'b0;
      r_addrErr   <= 1'b0;
      case (r_state)
        CLEAR: begin
          r_clearCnt <= r_clearCnt + 1'b1;
          if ((CLEAR_ON_RESET == 0) || w_lastClear) begin
            r_state    <= RUN;
            r_clearCnt <= '0;
          end
        end
        RUN: begin
          if (req) begin
            r_addrErr <= ~w_inRange;
            if (!wr_enable) begin
              r_doutValid <= 1'b1;
              r_dout      <= w_inRange ? r_mem[address] : '0;
            end
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  // Storage is deliberately unreset so contents survive when the sweep is off.
  always_ff @(posedge clk) begin
    if (w_clearWe) begin
      r_mem[r_clearCnt] <= '0;
    end else if (w_wrAccept) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (byte_en[i]) begin
          r_mem[address][8*i +: 8] <= din[8*i +: 8];
        end
      end
    end
  end

  assign ready      = w_ready;
  assign dout       = r_dout;
  assign dout_valid = r_doutValid;
  assign addr_err   = r_addrErr;

endmodule

// File: tb/tb_data_memory_be.sv
// Directed self-checking bench for data_memory_be (DEPTH=1000, zero-fill on).
module tb_data_memory_be;

  logic        clk;
  logic        reset_n;
  logic        req;
  logic        wr_enable;
  logic [9:0]  address;
  logic [31:0] din;
  logic [3:0]  byte_en;
  logic        ready;
  logic [31:0] dout;
  logic        dout_valid;
  logic        addr_err;

  int checks;
  int errors;

  data_memory_be #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(10),
    .DEPTH(1000),
    .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .req(req),
    .wr_enable(wr_enable),
    .address(address),
    .din(din),
    .byte_en(byte_en),
    .ready(ready),
    .dout(dout),
    .dout_valid(dout_valid),
    .addr_err(addr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Drive one request, let one rising edge pass, and return 1 ns after it.
  task automatic applyStimulus(input logic r, input logic we, input logic [9:0] a,
                               input logic [31:0] d, input logic [3:0] be);
    req       = r;
    wr_enable = we;
    address   = a;
    din       = d;
    byte_en   = be;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 10'd0, 32'd0, 4'd0);
  endtask

  // Hold a write request through the fill and count edges until ready rises.
  task automatic waitReady(output int cycles, output int strayPulses);
    cycles      = 0;
    strayPulses = 0;
    req       = 1'b1;
    wr_enable = 1'b1;
    address   = 10'd25;
    din       = 32'hDEADBEEF;
    byte_en   = 4'hF;
    while (ready !== 1'b1 && cycles < 3000) begin
      @(posedge clk);
      #1;
      cycles++;
      if (ready !== 1'b1 && (dout_valid !== 1'b0 || addr_err !== 1'b0)) strayPulses++;
    end
    req = 1'b0;
  endtask

  int cyc;
  int stray;

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    req       = 1'b0;
    wr_enable = 1'b0;
    address   = '0;
    din       = '0;
    byte_en   = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("rst_dout", dout, 32'd0);
    checkOutput("rst_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("rst_err", {31'd0, addr_err}, 32'd0);

    reset_n = 1'b1;
    waitReady(cyc, stray);
    checkOutput("clear_len", cyc, 1000);
    checkOutput("clear_ignore_req", stray, 0);

    applyStimulus(1'b1, 1'b0, 10'd25, 32'd0, 4'h0);
    checkOutput("rd25_clear_dout", dout, 32'h0);
    checkOutput("rd25_clear_valid", {31'd0, dout_valid}, 32'd1);
    idle();
    checkOutput("valid_one_cycle", {31'd0, dout_valid}, 32'd0);

    applyStimulus(1'b1, 1'b1, 10'd25, 32'h0000057F, 4'hF);
    checkOutput("wr_no_valid", {31'd0, dout_valid}, 32'd0);
    applyStimulus(1'b1, 1'b1, 10'd999, 32'h00000014, 4'hF);
    applyStimulus(1'b1, 1'b1, 10'd0, 32'hFFFFFFFF, 4'hF);
    checkOutput("wr_keeps_dout", dout, 32'h0);
    applyStimulus(1'b1, 1'b0, 10'd25, 32'd0, 4'h0);
    checkOutput("b2b_rd25", dout, 32'h0000057F);
    checkOutput("b2b_v1", {31'd0, dout_valid}, 32'd1);
    applyStimulus(1'b1, 1'b0, 10'd999, 32'd0, 4'h0);
    checkOutput("b2b_rd999", dout, 32'h00000014);
    checkOutput("b2b_v2", {31'd0, dout_valid}, 32'd1);
    applyStimulus(1'b1, 1'b0, 10'd0, 32'd0, 4'h0);
    checkOutput("b2b_rd0", dout, 32'hFFFFFFFF);
    checkOutput("b2b_v3", {31'd0, dout_valid}, 32'd1);
    idle();
    checkOutput("dout_hold", dout, 32'hFFFFFFFF);
    checkOutput("hold_valid", {31'd0, dout_valid}, 32'd0);

    applyStimulus(1'b1, 1'b1, 10'd700, 32'hAABBCCDD, 4'hF);
    applyStimulus(1'b1, 1'b1, 10'd700, 32'h11223344, 4'h5);
    applyStimulus(1'b1, 1'b1, 10'd700, 32'h99999999, 4'h0);
    applyStimulus(1'b1, 1'b0, 10'd700, 32'd0, 4'h0);
    checkOutput("byte_en_merge", dout, 32'hAA22CC44);

    applyStimulus(1'b1, 1'b1, 10'd1000, 32'h12345678, 4'hF);
    checkOutput("oor_wr_err", {31'd0, addr_err}, 32'd1);
    checkOutput("oor_wr_valid", {31'd0, dout_valid}, 32'd0);
    applyStimulus(1'b1, 1'b0, 10'd1000, 32'd0, 4'h0);
    checkOutput("oor_rd_err", {31'd0, addr_err}, 32'd1);
    checkOutput("oor_rd_valid", {31'd0, dout_valid}, 32'd1);
    checkOutput("oor_rd_dout", dout, 32'h0);
    applyStimulus(1'b1, 1'b0, 10'd999, 32'd0, 4'h0);
    checkOutput("rd999_after_oor", dout, 32'h00000014);
    checkOutput("err_one_cycle", {31'd0, addr_err}, 32'd0);

    applyStimulus(1'b1, 1'b1, 10'd5, 32'hCAFEF00D, 4'hF);
    applyStimulus(1'b1, 1'b0, 10'd5, 32'd0, 4'h0);
    checkOutput("raw_rd5", dout, 32'hCAFEF00D);

    // Read in flight when reset hits: its result must never surface.
    req       = 1'b1;
    wr_enable = 1'b0;
    address   = 10'd0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("inflight_valid", {31'd0, dout_valid}, 32'd0);
    checkOutput("inflight_dout", dout, 32'h0);
    req = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("inflight_valid_edge", {31'd0, dout_valid}, 32'd0);
    reset_n = 1'b1;

    repeat (500) @(posedge clk);
    #1;
    checkOutput("mid_clear_ready", {31'd0, ready}, 32'd0);
    reset_n = 1'b0;
    #1;
    checkOutput("mid_rst_ready", {31'd0, ready}, 32'd0);
    checkOutput("mid_rst_dout", dout, 32'h0);
    checkOutput("mid_rst_cnt", {22'd0, dut.r_clearCnt}, 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    waitReady(cyc, stray);
    checkOutput("reclear_len", cyc, 1000);
    checkOutput("reclear_ignore_req", stray, 0);

    applyStimulus(1'b1, 1'b0, 10'd5, 32'd0, 4'h0);
    checkOutput("rd5_cleared", dout, 32'h0);
    applyStimulus(1'b1, 1'b0, 10'd25, 32'd0, 4'h0);
    checkOutput("rd25_no_clear_write", dout, 32'h0);
    applyStimulus(1'b1, 1'b0, 10'd999, 32'd0, 4'h0);
    checkOutput("rd999_cleared", dout, 32'h0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
